// File: rtl/sobel_pkg.sv
// Shared constants and helpers for the Sobel datapath: sample format, window
// geometry and default image dimensions.
package sobel_pkg;

  localparam int DATA_W   = 16;
  localparam int Q_INT    = 8;
  localparam int Q_FRAC   = 8;
  localparam int WIN_TAPS = 9;

  localparam int IMG_W_DEF = 640;
  localparam int IMG_H_DEF = 480;
  localparam int COL_W     = $clog2(IMG_W_DEF);
  localparam int ROW_W     = $clog2(IMG_H_DEF);

  // Bit offset of window sample (r,c) in the flattened 9*n window bus.
  function automatic int win_off(input int r, input int c, input int n);
    return n * (3 * r + c);
  endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// One image line of delay: circular RAM with a single pointer; the oldest
// entry is read combinationally and replaced on each shift strobe.
module sobel_line_buffer
  import sobel_pkg::*;
#(
  parameter int N     = DATA_W,
  parameter int DEPTH = IMG_W_DEF
) (
  input  logic         clk,
  input  logic         sclr_n,
  input  logic         shift,
  input  logic [N-1:0] din,
  output logic [N-1:0] dout
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [N-1:0]  mem [DEPTH];
  logic [PW-1:0] ptr;

  assign dout = mem[ptr];

  always_ff @(posedge clk or negedge sclr_n) begin
    if (!sclr_n) begin
      ptr <= '0;
    end else if (shift) begin
      if (ptr == PW'(DEPTH - 1)) ptr <= '0;
      else                       ptr <= ptr + 1'b1;
    end
  end

  // RAM contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (shift) mem[ptr] <= din;
  end

endmodule

// File: rtl/sobel_window_gen.sv
// Streaming 3x3 interior-window generator for the Sobel MAC.
// Optional SOBEL_WIN_MARKERS_EN adds out_sof / out_eol window markers.
module sobel_window_gen
  import sobel_pkg::*;
#(
  parameter int N     = DATA_W,
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF
) (
  input  logic                  clk,
  input  logic                  sclr_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N-1:0]          in_pixel,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIN_TAPS*N-1:0] out_win
`ifdef SOBEL_WIN_MARKERS_EN
  ,
  output logic                  out_sof,
  output logic                  out_eol
`endif
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  logic [CW-1:0]           col;
  logic [RW-1:0]           row;
  logic [N-1:0]            lb1_out;
  logic [N-1:0]            lb2_out;
  logic [WIN_TAPS*N-1:0]   win_q;
  logic [WIN_TAPS*N-1:0]   win_d;
  logic                    accept;
  logic                    load;
  logic                    col_last;
  logic                    row_last;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign col_last = (col == CW'(IMG_W - 1));
  assign row_last = (row == RW'(IMG_H - 1));
  assign load     = accept && (col >= CW'(2)) && (row >= RW'(2));

  sobel_line_buffer #(.N(N), .DEPTH(IMG_W)) u_lb1 (
    .clk    (clk),
    .sclr_n (sclr_n),
    .shift  (accept),
    .din    (in_pixel),
    .dout   (lb1_out)
  );

  sobel_line_buffer #(.N(N), .DEPTH(IMG_W)) u_lb2 (
    .clk    (clk),
    .sclr_n (sclr_n),
    .shift  (accept),
    .din    (lb1_out),
    .dout   (lb2_out)
  );

  always_ff @(posedge clk or negedge sclr_n) begin
    if (!sclr_n) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col_last) begin
        col <= '0;
        row <= row_last ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Shift left one column; the new right column is the vertical stack at col.
  always_comb begin
    win_d = win_q;
    for (int r = 0; r < 3; r++) begin
      win_d[win_off(r, 0, N) +: N] = win_q[win_off(r, 1, N) +: N];
      win_d[win_off(r, 1, N) +: N] = win_q[win_off(r, 2, N) +: N];
    end
    win_d[win_off(0, 2, N) +: N] = lb2_out;
    win_d[win_off(1, 2, N) +: N] = lb1_out;
    win_d[win_off(2, 2, N) +: N] = in_pixel;
  end

  always_ff @(posedge clk or negedge sclr_n) begin
    if (!sclr_n) begin
      win_q <= '0;
    end else if (accept) begin
      win_q <= win_d;
    end
  end

  // A freshly loaded window takes priority over the consume of the old one.
  always_ff @(posedge clk or negedge sclr_n) begin
    if (!sclr_n) begin
      out_valid <= 1'b0;
      out_win   <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_win   <= win_d;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef SOBEL_WIN_MARKERS_EN
  always_ff @(posedge clk or negedge sclr_n) begin
    if (!sclr_n) begin
      out_sof <= 1'b0;
      out_eol <= 1'b0;
    end else if (load) begin
      out_sof <= (col == CW'(2)) && (row == RW'(2));
      out_eol <= col_last;
    end
  end
`endif

endmodule

// File: tb/tb_sobel_window_gen.sv
// Directed bench for sobel_window_gen on a 5x4 image with hand-derived windows.
module tb_sobel_window_gen;

  localparam int N  = 16;
  localparam int W  = 5;
  localparam int H  = 4;
  localparam int WB = 9 * N;

  logic          clk = 1'b0;
  logic          sclr_n;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_pixel;
  logic          out_valid;
  logic          out_ready;
  logic [WB-1:0] out_win;
`ifdef SOBEL_WIN_MARKERS_EN
  logic          out_sof;
  logic          out_eol;
`endif

  int total = 0;
  int bad   = 0;

  logic [WB-1:0] wins [$];
  logic [1:0]    marks [$];

  always #5 clk = ~clk;

  sobel_window_gen #(.N(N), .IMG_W(W), .IMG_H(H)) dut (
    .clk       (clk),
    .sclr_n    (sclr_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pixel  (in_pixel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_win   (out_win)
`ifdef SOBEL_WIN_MARKERS_EN
    ,
    .out_sof   (out_sof),
    .out_eol   (out_eol)
`endif
  );

  // Record every window consumed by the downstream side.
  always @(negedge clk) begin
    if (sclr_n && out_valid && out_ready) begin
      wins.push_back(out_win);
`ifdef SOBEL_WIN_MARKERS_EN
      marks.push_back({out_sof, out_eol});
`else
      marks.push_back(2'b00);
`endif
    end
  end

  function automatic logic [WB-1:0] exp_win(input int base, input int c0, input int r0);
    logic [WB-1:0] w;
    w = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        w[N*(3*r+c) +: N] = N'(base + (r0 + r) * W + c0 + c);
    return w;
  endfunction

  task automatic check(input string tag, input logic [WB-1:0] obs, input logic [WB-1:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input int v, input bit gaps);
    int guard;
    guard = 0;
    if (gaps && ($urandom_range(0, 99) < 30)) @(negedge clk);
    @(negedge clk);
    in_valid = 1'b1;
    in_pixel = N'(v);
    #1;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (!in_ready) check("send_timeout", WB'(in_ready), WB'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_range(input int first, input int last, input bit gaps);
    for (int v = first; v <= last; v++) send(v, gaps);
  endtask

  task automatic drain();
    repeat (4) @(negedge clk);
  endtask

  task automatic check_frame(input string tag, input int qoff, input int base);
    for (int k = 0; k < 6; k++)
      check($sformatf("%s_win%0d", tag, k), wins[qoff + k], exp_win(base, k % 3, k / 3));
  endtask

  initial begin
    sclr_n    = 1'b0;
    in_valid  = 1'b0;
    in_pixel  = '0;
    out_ready = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_out_valid", WB'(out_valid), WB'(0));
    check("rst_in_ready", WB'(in_ready), WB'(1));
    check("rst_out_win", out_win, '0);
    @(negedge clk);
    sclr_n = 1'b1;

    // Single frame, free-flowing output, first-window latency
    send_range(0, 11, 1'b0);
    check("pre12_out_valid", WB'(out_valid), WB'(0));
    send(12, 1'b0);
    check("post12_out_valid", WB'(out_valid), WB'(1));
    check("post12_out_win", out_win, exp_win(0, 0, 0));
    send_range(13, 19, 1'b0);
    drain();
    check("f1_count", WB'(wins.size()), WB'(6));
    check_frame("f1", 0, 0);
    check("f1_last", wins[5], exp_win(0, 2, 1));
`ifdef SOBEL_WIN_MARKERS_EN
    for (int k = 0; k < 6; k++)
      check($sformatf("marks%0d", k), WB'(marks[k]), WB'({k == 0, (k % 3) == 2}));
`endif
    wins.delete();
    marks.delete();

    // Backpressure while a window is pending; pixel 13 offered but must wait
    send_range(0, 12, 1'b0);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_pixel  = N'(13);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("stall%0d_in_ready", i), WB'(in_ready), WB'(0));
      check($sformatf("stall%0d_out_valid", i), WB'(out_valid), WB'(1));
      check($sformatf("stall%0d_out_win", i), out_win, exp_win(0, 0, 0));
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    send_range(13, 19, 1'b0);
    drain();
    check("stall_count", WB'(wins.size()), WB'(6));
    check_frame("stall", 0, 0);
    wins.delete();

    // Back-to-back frames
    send_range(0, 19, 1'b0);
    send_range(100, 119, 1'b0);
    drain();
    check("b2b_count", WB'(wins.size()), WB'(12));
    check("b2b_win7", wins[6], exp_win(100, 0, 0));
    check_frame("b2b_f1", 0, 0);
    check_frame("b2b_f2", 6, 100);
    wins.delete();

    // Random input gaps
    send_range(0, 19, 1'b1);
    drain();
    check("gap_count", WB'(wins.size()), WB'(6));
    check_frame("gap", 0, 0);
    wins.delete();

    // Reset mid-frame, then restart
    send_range(0, 8, 1'b0);
    sclr_n = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", WB'(out_valid), WB'(0));
    check("midrst_in_ready", WB'(in_ready), WB'(1));
    @(negedge clk);
    sclr_n = 1'b1;
    send_range(0, 19, 1'b0);
    drain();
    check("rst_count", WB'(wins.size()), WB'(6));
    check_frame("rst", 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
